// File: rtl/fp_add_align.sv
// FP32 adder pre-alignment: unpack, magnitude swap, special-case bypass, and
// sticky right-shift of the smaller significand, as a 2-stage valid/ready pipe.
module fp_add_align #(
    parameter int SHIFT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    output logic [7:0]  exp_out,
    output logic        sign_out,
    output logic        eff_sub,
    output logic        spec_flag,
    output logic [31:0] spec_result
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // pipeline handshake
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;

    // stage 1 combinational results
    logic               sign_a;
    logic               sign_b;
    logic [7:0]         exp_a;
    logic [7:0]         exp_b;
    logic [7:0]         eff_exp_a;
    logic [7:0]         eff_exp_b;
    logic [23:0]        sig_a;
    logic [23:0]        sig_b;
    logic               a_is_l;
    logic               mag_tie;
    logic               nan_a;
    logic               nan_b;
    logic               inf_a;
    logic               inf_b;
    logic [7:0]         exp_diff;
    logic [SHIFT_W-1:0] d_c;
    logic [23:0]        l_sig_c;
    logic [23:0]        s_sig_c;
    logic [7:0]         l_exp_c;
    logic               sub_c;
    logic               sign_c;
    logic               spec_c;
    logic [31:0]        spec_res_c;

    // stage 1 registers
    logic [23:0]        s1_l_sig;
    logic [23:0]        s1_s_sig;
    logic [SHIFT_W-1:0] s1_d;
    logic [7:0]         s1_exp;
    logic               s1_sign;
    logic               s1_eff_sub;
    logic               s1_spec;
    logic [31:0]        s1_spec_result;

    // stage 2 combinational results
    logic [31:0] l_word;
    logic [31:0] s_word;
    logic [31:0] shifted;
    logic [31:0] lost_mask;
    logic        sticky;
    logic [31:0] aligned;
    logic [31:0] b_word;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    always_comb begin
        sign_a     = op_a[31];
        sign_b     = op_b[31] ^ op_sub;
        exp_a      = op_a[30:23];
        exp_b      = op_b[30:23];
        eff_exp_a  = (exp_a == 8'd0) ? 8'd1 : exp_a;
        eff_exp_b  = (exp_b == 8'd0) ? 8'd1 : exp_b;
        sig_a      = {(exp_a != 8'd0), op_a[22:0]};
        sig_b      = {(exp_b != 8'd0), op_b[22:0]};
        nan_a      = (exp_a == 8'hFF) && (op_a[22:0] != 23'd0);
        nan_b      = (exp_b == 8'hFF) && (op_b[22:0] != 23'd0);
        inf_a      = (exp_a == 8'hFF) && (op_a[22:0] == 23'd0);
        inf_b      = (exp_b == 8'hFF) && (op_b[22:0] == 23'd0);
        a_is_l     = op_a[30:0] >= op_b[30:0];
        mag_tie    = op_a[30:0] == op_b[30:0];
        sub_c      = sign_a ^ sign_b;

        l_sig_c    = a_is_l ? sig_a : sig_b;
        s_sig_c    = a_is_l ? sig_b : sig_a;
        l_exp_c    = a_is_l ? eff_exp_a : eff_exp_b;
        exp_diff   = a_is_l ? (eff_exp_a - eff_exp_b) : (eff_exp_b - eff_exp_a);
        d_c        = (exp_diff > 8'd27) ? SHIFT_W'(27) : SHIFT_W'(exp_diff);

        // an exact cancellation yields +0 regardless of operand signs
        sign_c     = (mag_tie && sub_c) ? 1'b0 : (a_is_l ? sign_a : sign_b);

        spec_c     = 1'b0;
        spec_res_c = 32'd0;
        if (nan_a || nan_b) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN;
        end else if (inf_a && inf_b && sub_c) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN;
        end else if (inf_a) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_a, 8'hFF, 23'd0};
        end else if (inf_b) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_b, 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_l_sig       <= '0;
            s1_s_sig       <= '0;
            s1_d           <= '0;
            s1_exp         <= '0;
            s1_sign        <= 1'b0;
            s1_eff_sub     <= 1'b0;
            s1_spec        <= 1'b0;
            s1_spec_result <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_l_sig       <= l_sig_c;
                s1_s_sig       <= s_sig_c;
                s1_d           <= d_c;
                s1_exp         <= l_exp_c;
                s1_sign        <= sign_c;
                s1_eff_sub     <= sub_c;
                s1_spec        <= spec_c;
                s1_spec_result <= spec_res_c;
            end
        end
    end

    // everything shifted past bit 0 collapses into the sticky bit
    always_comb begin
        l_word    = {5'b0, s1_l_sig, 3'b000};
        s_word    = {5'b0, s1_s_sig, 3'b000};
        shifted   = s_word >> s1_d;
        lost_mask = (32'd1 << s1_d) - 32'd1;
        sticky    = |(s_word & lost_mask);
        aligned   = {shifted[31:1], shifted[0] | sticky};
        b_word    = s1_eff_sub ? ~aligned : aligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            exp_out     <= '0;
            sign_out    <= 1'b0;
            eff_sub     <= 1'b0;
            spec_flag   <= 1'b0;
            spec_result <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                add_a       <= l_word;
                add_b       <= b_word;
                add_cin     <= s1_eff_sub;
                exp_out     <= s1_exp;
                sign_out    <= s1_sign;
                eff_sub     <= s1_eff_sub;
                spec_flag   <= s1_spec;
                spec_result <= s1_spec_result;
            end
        end
    end

endmodule
